// File: rtl/brew_sequencer_if.sv
// ============================================================================
// Module   : brew_sequencer_if
// Purpose  : Bundles the brew request inputs and the status/actuator outputs
//            of the brew sequencer into one interface.
// Ports    : master modport - drives start, bb, ha, hc, abort; reads status.
//            slave  modport - reads requests; drives busy, done, fault,
//                             fault_code, state and the four actuator enables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface brew_sequencer_if;
  logic       start;       // brew request
  logic       bb;          // drink size: 0 small, 1 large
  logic       ha;          // water present
  logic       hc;          // coffee present
  logic       abort;       // cancel / clear fault
  logic       busy;
  logic       done;
  logic       fault;
  logic [1:0] fault_code;  // {no coffee, no water}
  logic [2:0] state;
  logic       grind_on;
  logic       heat_on;
  logic       valve_on;
  logic       pump_on;

  modport master (
    output start, bb, ha, hc, abort,
    input  busy, done, fault, fault_code, state,
    input  grind_on, heat_on, valve_on, pump_on
  );

  modport slave (
    input  start, bb, ha, hc, abort,
    output busy, done, fault, fault_code, state,
    output grind_on, heat_on, valve_on, pump_on
  );
endinterface

`default_nettype wire

// File: rtl/brew_sequencer.sv
// ============================================================================
// Module   : brew_sequencer
// Purpose  : Coffee brew sequencer. Steps GRIND -> HEAT -> (PREINF) -> PUMP ->
//            DRIP -> DONE -> IDLE using a single 8-bit stage down-counter,
//            with ingredient faults and abort.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-low reset
//            bus  - brew_sequencer_if.slave (requests in, status/actuators out)
// Config   : define BREW_PREINFUSE_EN to insert the PREINF stage (valve open,
//            pump off) between HEAT and PUMP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module brew_sequencer #(
  parameter int GRIND_CYC  = 20,
  parameter int HEAT_CYC   = 30,
  parameter int PUMP_S_CYC = 40,
  parameter int PUMP_L_CYC = 80,
  parameter int PREINF_CYC = 8,
  parameter int DRIP_CYC   = 10
) (
  input  wire logic         clk,
  input  wire logic         rst,
  brew_sequencer_if.slave   bus
);

`ifdef BREW_PREINFUSE_EN
  localparam bit PREINF_EN = 1'b1;
`else
  localparam bit PREINF_EN = 1'b0;
`endif

  // Counter is loaded with length-1 so a stage lasts exactly its length.
  localparam logic [7:0] GRIND_LOAD  = 8'(GRIND_CYC - 1);
  localparam logic [7:0] HEAT_LOAD   = 8'(HEAT_CYC - 1);
  localparam logic [7:0] PUMP_S_LOAD = 8'(PUMP_S_CYC - 1);
  localparam logic [7:0] PUMP_L_LOAD = 8'(PUMP_L_CYC - 1);
  localparam logic [7:0] PREINF_LOAD = 8'(PREINF_CYC - 1);
  localparam logic [7:0] DRIP_LOAD   = 8'(DRIP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRIND  = 3'd1,
    HEAT   = 3'd2,
    PREINF = 3'd3,
    PUMP   = 3'd4,
    DRIP   = 3'd5,
    DONE   = 3'd6,
    FAULT  = 3'd7
  } state_t;

  state_t     cur_state, next_state;
  logic [7:0] count, next_count;
  logic       size, next_size;
  logic [1:0] code, next_code;
  logic [7:0] pump_load;

  logic busy_reg, done_reg, fault_reg;
  logic grind_reg, heat_reg, valve_reg, pump_reg;

  assign pump_load = size ? PUMP_L_LOAD : PUMP_S_LOAD;

  // Next-state / counter logic. Abort outranks every fault and stage exit;
  // within a stage, an ingredient fault outranks the stage exit.
  always_comb begin
    next_state = cur_state;
    next_count = count;
    next_size  = size;
    next_code  = code;
    if (cur_state != IDLE && bus.abort) begin
      next_state = IDLE;
      next_count = 8'd0;
      next_code  = 2'b00;
    end else begin
      case (cur_state)
        IDLE: begin
          if (bus.start) begin
            if (bus.ha && bus.hc) begin
              next_state = GRIND;
              next_count = GRIND_LOAD;
              next_size  = bus.bb;
            end else begin
              next_state = FAULT;
              next_count = 8'd0;
              next_code  = {~bus.hc, ~bus.ha};
            end
          end
        end
        GRIND: begin
          if (!bus.hc) begin
            next_state = FAULT;
            next_count = 8'd0;
            next_code  = 2'b10;
          end else if (count == 8'd0) begin
            next_state = HEAT;
            next_count = HEAT_LOAD;
          end else begin
            next_count = count - 8'd1;
          end
        end
        HEAT: begin
          if (!bus.ha) begin
            next_state = FAULT;
            next_count = 8'd0;
            next_code  = 2'b01;
          end else if (count == 8'd0) begin
            next_state = PREINF_EN ? PREINF : PUMP;
            next_count = PREINF_EN ? PREINF_LOAD : pump_load;
          end else begin
            next_count = count - 8'd1;
          end
        end
`ifdef BREW_PREINFUSE_EN
        PREINF: begin
          if (!bus.ha) begin
            next_state = FAULT;
            next_count = 8'd0;
            next_code  = 2'b01;
          end else if (count == 8'd0) begin
            next_state = PUMP;
            next_count = pump_load;
          end else begin
            next_count = count - 8'd1;
          end
        end
`endif
        PUMP: begin
          if (!bus.ha) begin
            next_state = FAULT;
            next_count = 8'd0;
            next_code  = 2'b01;
          end else if (count == 8'd0) begin
            next_state = DRIP;
            next_count = DRIP_LOAD;
          end else begin
            next_count = count - 8'd1;
          end
        end
        DRIP: begin
          if (count == 8'd0) begin
            next_state = DONE;
            next_count = 8'd0;
          end else begin
            next_count = count - 8'd1;
          end
        end
        DONE: begin
          next_state = IDLE;
        end
        FAULT: begin
          // Held until abort; start is ignored here.
        end
        default: begin
          // Unreachable encodings recover to IDLE.
          next_state = IDLE;
          next_count = 8'd0;
          next_code  = 2'b00;
        end
      endcase
    end
  end

  // State register plus outputs registered from the next state, so every
  // output is a clean Moore decode of the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= IDLE;
      count     <= 8'd0;
      size      <= 1'b0;
      code      <= 2'b00;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      fault_reg <= 1'b0;
      grind_reg <= 1'b0;
      heat_reg  <= 1'b0;
      valve_reg <= 1'b0;
      pump_reg  <= 1'b0;
    end else begin
      cur_state <= next_state;
      count     <= next_count;
      size      <= next_size;
      code      <= next_code;
      busy_reg  <= (next_state == GRIND) || (next_state == HEAT) ||
                   (PREINF_EN && next_state == PREINF) ||
                   (next_state == PUMP) || (next_state == DRIP);
      done_reg  <= (next_state == DONE);
      fault_reg <= (next_state == FAULT);
      grind_reg <= (next_state == GRIND);
      heat_reg  <= (next_state == HEAT) || (next_state == PUMP) ||
                   (PREINF_EN && next_state == PREINF);
      valve_reg <= (next_state == PUMP) ||
                   (PREINF_EN && next_state == PREINF);
      pump_reg  <= (next_state == PUMP);
    end
  end

  assign bus.state      = cur_state;
  assign bus.fault_code = code;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.fault      = fault_reg;
  assign bus.grind_on   = grind_reg;
  assign bus.heat_on    = heat_reg;
  assign bus.valve_on   = valve_reg;
  assign bus.pump_on    = pump_reg;

endmodule

`default_nettype wire

// File: doc/brew_sequencer.md
BREW_SEQUENCER -- requirements
Module: brew_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): GRIND_CYC, 20, grind stage length in cycles.
REQ-002 SHALL have HEAT_CYC, 30, heat stage length; PUMP_S_CYC, 40, small-drink pump length; PUMP_L_CYC, 80, large-drink pump length.
REQ-003 SHALL have PREINF_CYC, 8, pre-infusion length; DRIP_CYC, 10, drip stage length; every length legal range 1..255.
REQ-004 SHALL have ports (name, direction, width, meaning): clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have start, input, 1, brew request; bb, input, 1, drink size (0 small, 1 large); ha, input, 1, water present; hc, input, 1, coffee present; abort, input, 1, cancel/clear.
REQ-007 SHALL have busy, output, 1; done, output, 1; fault, output, 1; fault_code, output, 2; state, output, 3.
REQ-008 SHALL have grind_on, heat_on, valve_on, pump_on, each output, 1, actuator enables.

Function
REQ-009 SHALL encode states IDLE=0, GRIND=1, HEAT=2, PREINF=3, PUMP=4, DRIP=5, DONE=6, FAULT=7; state output equals the state register.
REQ-010 SHALL use one 8-bit down-counter, loaded with stage length minus 1 on stage entry; stage exits on the edge where counter==0, so each stage lasts exactly its parameter in cycles.
REQ-011 In IDLE, start=1 with ha=1 and hc=1 SHALL enter GRIND on that edge and latch bb; bb changes afterwards are ignored until the next brew.
REQ-012 In IDLE, start=1 with ha=0 or hc=0 SHALL enter FAULT with fault_code = {~hc, ~ha} (01 no water, 10 no coffee, 11 both).
REQ-013 Transitions SHALL be GRIND->HEAT->PUMP->DRIP->DONE->IDLE (PREINF inserted per REQ-024); DONE lasts exactly one cycle.
REQ-014 PUMP length SHALL be PUMP_L_CYC when latched bb=1, else PUMP_S_CYC.
REQ-015 hc=0 during GRIND SHALL enter FAULT next edge with fault_code=10.
REQ-016 ha=0 during HEAT, PREINF or PUMP SHALL enter FAULT next edge with fault_code=01.
REQ-017 abort=1 in any state other than IDLE SHALL enter IDLE next edge, no done pulse; abort has priority over every fault condition and stage exit.
REQ-018 FAULT SHALL hold, fault=1 and fault_code stable, until abort=1; start is ignored in FAULT.
REQ-019 start SHALL be ignored in every state except IDLE; a start held high through DONE starts a new brew on the first IDLE cycle only if ha and hc are high.
REQ-020 Outputs SHALL be Moore-decoded from the state register: grind_on in GRIND; heat_on in HEAT, PREINF, PUMP; valve_on in PREINF, PUMP; pump_on in PUMP; busy in GRIND..DRIP; done in DONE; fault in FAULT.
REQ-021 fault_code SHALL read 00 in every state except FAULT.

Reset
REQ-022 rst=0 SHALL immediately force IDLE, counter=0, latched size=0, fault_code=00, all outputs 0, regardless of clk, including mid-brew.
REQ-023 After rst returns high, first start SHALL be accepted on the first rising edge.

Configuration
REQ-024 With macro BREW_PREINFUSE_EN defined, HEAT SHALL exit to PREINF (PREINF_CYC cycles, valve open, pump off), then PUMP.
REQ-025 Without BREW_PREINFUSE_EN, HEAT SHALL exit directly to PUMP, PREINF is unreachable, and any illegal state value (3 included) SHALL return to IDLE next edge with all outputs 0.

Verification
REQ-026 Defaults, no macro, ha=hc=1, bb=0, start pulse at edge E0 -> GRIND E0-E19, HEAT E20-E49, PUMP E50-E89, DRIP E90-E99, done=1 after E100 for one cycle, IDLE after E101.
REQ-027 Same with bb=1 -> pump_on high 80 cycles, done after E140; with BREW_PREINFUSE_EN and bb=0 -> valve_on without pump_on for 8 cycles, done after E108.
REQ-028 start with ha=0, hc=0 -> FAULT next edge, fault_code=11, all actuators 0; abort=1 -> IDLE, fault=0.
REQ-029 ha dropped to 0 on PUMP cycle 10 -> FAULT next edge, pump_on/valve_on/heat_on 0, fault_code=01; abort and ha=0 on same edge in PUMP -> IDLE, fault=0.
REQ-030 rst=0 asserted between edges mid-HEAT -> heat_on=0 and state=0 before next edge; start after release -> full 100-cycle brew.
REQ-031 start pulsed during HEAT and bb toggled during GRIND -> no effect on timeline or pump length.
